sar_adc_seq_wb: RTL

//  Wishbone-slave sequencer for the SAR ADC macro; successor to the fixed single-channel adc_wrapper core.

---
 rtl/sar_adc_pkg.sv | 60 ++++++
 rtl/sar_adc_fifo.sv | 63 ++++++
 rtl/sar_adc_seq_wb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_pkg
//  Description : Shared definitions for the SAR ADC Wishbone sequencer:
//                FSM state encoding, register word offsets, register field
//                positions and a lowest-set-bit channel search helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sar_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_STORE   = 3'd4,
    ST_NEXT    = 3'd5
  } state_e;

  // Word offsets, i.e. byte address bits [4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_CHMASK = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_IRQCFG = 3'd4;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_START     = 2;
  localparam int CTRL_DIV_LSB   = 8;
  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int DATA_VALID     = 31;
  localparam int DATA_CH_LSB    = 16;
  localparam int IRQ_IE         = 0;
  localparam int IRQ_THR_LSB    = 8;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } chsel_t;

  // Lowest set bit of mask at or above 'from'; found=0 when none remains.
  function automatic chsel_t first_set(input logic [15:0] mask, input logic [4:0] from);
    chsel_t r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_adc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_fifo
//  Description : Synchronous show-ahead FIFO holding conversion results.
//                A push into a full FIFO is dropped unless a pop happens in
//                the same clock, in which case both succeed.
//  Revision    : 1.0  initial release
//  Ports       : clk_i, rst_i (async, active-high)
//                push_i/data_i   write side
//                pop_i/data_o    read side, data_o valid while !empty_o
//                level_o, full_o, empty_o  occupancy
// ============================================================================
module sar_adc_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic             w_do_push, w_do_pop;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign data_o    = mem_q[rd_q];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + 1'b1;
      if (w_do_pop)  rd_q <= rd_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_adc_seq_wb.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_seq_wb
//  Description : Wishbone-slave sequencer for a SAR ADC macro. Round-robin
//                scan over a channel mask, single-shot or continuous, with a
//                result FIFO and a level interrupt.
//  Revision    : 1.0  initial release
//  Ports       : wb_clk_i, wb_rst_i (async, active-high)
//                wbs_*     Wishbone slave, 1-cycle registered ack
//                cmp_i     comparator (1 = Vin >= Vdac)
//                dac_o     DAC trial code, sample_o S/H enable
//                ch_sel_o  analog mux select, irq_o level interrupt
// ============================================================================
module sar_adc_seq_wb
  import sar_adc_pkg::*;
#(
  parameter int RES        = 10,
  parameter int NCH        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_CYC = 4
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_i,
  input  logic                                   wbs_cyc_i,
  input  logic                                   wbs_stb_i,
  input  logic                                   wbs_we_i,
  input  logic [3:0]                             wbs_sel_i,
  input  logic [31:0]                            wbs_adr_i,
  input  logic [31:0]                            wbs_dat_i,
  output logic [31:0]                            wbs_dat_o,
  output logic                                   wbs_ack_o,
  input  logic                                   cmp_i,
  output logic [RES-1:0]                         dac_o,
  output logic                                   sample_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel_o,
  output logic                                   irq_o
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW  = (RES > 1) ? $clog2(RES) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int FW  = 4 + RES;

  // Register file
  logic           ack_q, en_q, cont_q, start_q, ovf_q, ie_q;
  logic [31:0]    dat_q;
  logic [7:0]     clkdiv_q, thresh_q;
  logic [NCH-1:0] chmask_q;

  // Sequencer state
  state_e         state_q, state_d;
  logic [3:0]     ch_q, ch_d;
  logic [7:0]     cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [RES-1:0] sar_q, sar_d;

  logic           w_acc, w_wr, w_rd, w_pop, w_push, w_set_ovf, w_tick;
  logic [2:0]     w_adr;
  logic [31:0]    w_rdata;
  logic [15:0]    w_mask16, w_mask_wr16;
  logic [FW-1:0]  w_fifo_dout;
  logic [LW-1:0]  w_level;
  logic           w_full, w_empty;
  logic [7:0]     w_thr_eff;
  chsel_t         w_first, w_next;

  // --------------------------------------------------------------------------
  // Wishbone decode
  // --------------------------------------------------------------------------
  assign w_acc = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign w_wr  = w_acc & wbs_we_i;
  assign w_rd  = w_acc & ~wbs_we_i;
  assign w_adr = wbs_adr_i[4:2];
  assign w_pop = w_rd & (w_adr == REG_DATA) & ~w_empty;

  always_comb begin
    w_mask16              = '0;
    w_mask16[NCH-1:0]     = chmask_q;
    w_mask_wr16[7:0]      = wbs_sel_i[0] ? wbs_dat_i[7:0]  : w_mask16[7:0];
    w_mask_wr16[15:8]     = wbs_sel_i[1] ? wbs_dat_i[15:8] : w_mask16[15:8];
  end

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      REG_CTRL: begin
        w_rdata[CTRL_EN]             = en_q;
        w_rdata[CTRL_CONT]           = cont_q;
        w_rdata[CTRL_DIV_LSB +: 8]   = clkdiv_q;
      end
      REG_CHMASK: w_rdata[NCH-1:0] = chmask_q;
      REG_STATUS: begin
        w_rdata[STAT_BUSY]           = (state_q != ST_IDLE);
        w_rdata[STAT_EMPTY]          = w_empty;
        w_rdata[STAT_FULL]           = w_full;
        w_rdata[STAT_OVF]            = ovf_q;
        w_rdata[STAT_LEVEL_LSB +: 8] = 8'(w_level);
      end
      REG_DATA: begin
        if (!w_empty) begin
          w_rdata[DATA_VALID]         = 1'b1;
          w_rdata[DATA_CH_LSB +: 4]   = w_fifo_dout[FW-1 -: 4];
          w_rdata[RES-1:0]            = w_fifo_dout[RES-1:0];
        end
      end
      REG_IRQCFG: begin
        w_rdata[IRQ_IE]              = ie_q;
        w_rdata[IRQ_THR_LSB +: 8]    = thresh_q;
      end
      default: w_rdata = '0;
    endcase
  end

  // A drop only counts as overflow when no pop frees a slot in the same clock.
  assign w_set_ovf = w_push & w_full & ~w_pop;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      start_q  <= 1'b0;
      clkdiv_q <= '0;
      chmask_q <= '0;
      ovf_q    <= 1'b0;
      ie_q     <= 1'b0;
      thresh_q <= '0;
    end else begin
      ack_q   <= w_acc;
      dat_q   <= w_rd ? w_rdata : '0;
      start_q <= 1'b0;
      if (w_set_ovf)
        ovf_q <= 1'b1;
      else if (w_wr && (w_adr == REG_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_OVF])
        ovf_q <= 1'b0;
      if (w_wr) begin
        case (w_adr)
          REG_CTRL: begin
            if (wbs_sel_i[0]) begin
              en_q    <= wbs_dat_i[CTRL_EN];
              cont_q  <= wbs_dat_i[CTRL_CONT];
              start_q <= wbs_dat_i[CTRL_START];
            end
            if (wbs_sel_i[1]) clkdiv_q <= wbs_dat_i[CTRL_DIV_LSB +: 8];
          end
          REG_CHMASK: chmask_q <= w_mask_wr16[NCH-1:0];
          REG_IRQCFG: begin
            if (wbs_sel_i[0]) ie_q     <= wbs_dat_i[IRQ_IE];
            if (wbs_sel_i[1]) thresh_q <= wbs_dat_i[IRQ_THR_LSB +: 8];
          end
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  // >= rather than == so a CLKDIV lowered mid-count ticks at once.
  assign w_tick = (state_q != ST_IDLE) && (div_q >= clkdiv_q);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sar_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sar_q   <= sar_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sar_d   = sar_q;
    div_d   = w_tick ? '0 : div_q + 8'd1;
    w_push  = 1'b0;
    w_first = first_set(w_mask16, 5'd0);
    w_next  = first_set(w_mask16, {1'b0, ch_q} + 5'd1);
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (start_q && en_q && w_first.found) begin
          state_d = ST_SELECT;
          ch_d    = w_first.idx;
        end
      end
      ST_SELECT: begin
        if (w_tick) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE: begin
        if (w_tick) begin
          if (cnt_q == 8'(SAMPLE_CYC - 1)) begin
            state_d = ST_CONVERT;
            bit_d   = BW'(RES - 1);
            sar_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_CONVERT: begin
        if (w_tick) begin
          sar_d[bit_q] = cmp_i;
          if (bit_q == '0) state_d = ST_STORE;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      ST_STORE: begin
        // Single-clock states restart the divider so SELECT settles a full tick.
        div_d   = '0;
        w_push  = 1'b1;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        div_d = '0;
        if (w_next.found) begin
          state_d = ST_SELECT;
          ch_d    = w_next.idx;
        end else if (cont_q && w_first.found) begin
          state_d = ST_SELECT;
          ch_d    = w_first.idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping EN abandons whatever is in flight; FIFO contents stay.
    if (!en_q && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      w_push  = 1'b0;
      div_d   = '0;
    end
  end

  sar_adc_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (w_push),
    .data_i  ({ch_q, sar_q}),
    .pop_i   (w_pop),
    .data_o  (w_fifo_dout),
    .level_o (w_level),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign dac_o    = (state_q == ST_CONVERT) ? (sar_q | ({{(RES-1){1'b0}}, 1'b1} << bit_q)) : '0;
  assign sample_o = (state_q == ST_SAMPLE);
  assign ch_sel_o = (state_q != ST_IDLE) ? ch_q[CHW-1:0] : '0;

  assign w_thr_eff = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
  assign irq_o     = ie_q & ((8'(w_level) >= w_thr_eff) | ovf_q);

  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i, w_mask_wr16, ch_q};

endmodule
`default_nettype wire
